// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier.
//   OP_*      : 2-bit operation encodings on the op port
//   state_t   : FSM state encoding (IDLE, CALC, FIX, DONE)
//   operand_signed() : which operands are read as two's complement for an op
package mul_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Returns {rs1_signed, rs2_signed}. MUL only delivers the low word,
    // which is the same for signed and unsigned operands, so it is unsigned.
    function automatic logic [1:0] operand_signed(input logic [1:0] op);
        logic [1:0] s;
        case (op)
            OP_MULH:   s = 2'b11;
            OP_MULHSU: s = 2'b10;
            default:   s = 2'b00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// N-bit ripple-carry adder used by the multiplier accumulate step.
//   a, b : N-bit addends
//   cin  : carry in
//   sum  : N-bit sum
//   cout : carry out of the top bit
module RippleCarryAdder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    // The carry is walked through a loop variable so the chain is a single
    // combinational pass rather than a self-referencing vector.
    always_comb begin
        logic c;
        c = cin;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier (RISC-V MUL/MULH/MULHSU/MULHU).
//   clk    : clock, all state changes on its rising edge
//   rst_n  : asynchronous active-low reset
//   start  : request a multiply (sampled in IDLE or DONE only)
//   op     : 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1    : multiplicand
//   rs2    : multiplier
//   busy   : high in CALC and FIX
//   done   : one-cycle pulse, result valid
//   result : low word (MUL) or high word (others) of the 2*XLEN-bit product
//
// Handshake: start is taken on a rising edge while busy is low and the FSM is
// in IDLE or DONE; operands need only be valid on that edge. done rises exactly
// 33 edges later for one cycle, and result then holds until the next FIX.
// start while busy is ignored.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    state_t state, next_state;
    logic   accept;

    logic [1:0]      op_q;
    logic            sign_q;
    logic [XLEN-1:0] mag1_q;
    logic [XLEN-1:0] hi, lo;
    logic [CW-1:0]   count;

    // Operand magnitudes; -2^(XLEN-1) maps onto itself as an unsigned value.
    logic [1:0]      sgn;
    logic            neg1, neg2;
    logic [XLEN-1:0] mag1, mag2;

    assign sgn  = operand_signed(op);
    assign neg1 = sgn[1] & rs1[XLEN-1];
    assign neg2 = sgn[0] & rs2[XLEN-1];
    assign mag1 = neg1 ? (~rs1 + XLEN'(1)) : rs1;
    assign mag2 = neg2 ? (~rs2 + XLEN'(1)) : rs2;

    // Accumulate step: add the multiplicand when the current multiplier bit
    // (lo[0]) is set; the carry becomes the top bit of the shifted hi word.
    logic [XLEN-1:0] add_sum;
    logic            add_cout;
    logic [XLEN-1:0] step_s;
    logic            step_c;

    RippleCarryAdder #(.N(XLEN)) u_adder (
        .a    (hi),
        .b    (mag1_q),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign step_c = lo[0] ? add_cout : 1'b0;
    assign step_s = lo[0] ? add_sum  : hi;

    // Sign fix-up of the full product before word selection.
    logic [2*XLEN-1:0] prod, prod_fixed;
    assign prod       = {hi, lo};
    assign prod_fixed = sign_q ? (~prod + (2*XLEN)'(1)) : prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end
            end
            CALC: begin
                if (count == CW'(XLEN - 1)) next_state = FIX;
            end
            FIX: begin
                next_state = DONE;
            end
            DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_MUL;
            sign_q <= 1'b0;
            mag1_q <= '0;
            hi     <= '0;
            lo     <= '0;
            count  <= '0;
            result <= '0;
        end else if (accept) begin
            op_q   <= op;
            sign_q <= neg1 ^ neg2;
            mag1_q <= mag1;
            hi     <= '0;
            lo     <= mag2;
            count  <= '0;
        end else if (state == CALC) begin
            hi    <= {step_c, step_s[XLEN-1:1]};
            lo    <= {step_s[0], lo[XLEN-1:1]};
            count <= count + CW'(1);   // wraps to 0 on the last iteration
        end else if (state == FIX) begin
            result <= (op_q == OP_MUL) ? prod_fixed[XLEN-1:0]
                                       : prod_fixed[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: fixed vectors with hand-computed results,
// latency and pulse-width checks, start-while-busy, mid-operation reset and
// back-to-back issue.
module tb_seq_multiplier;
    import mul_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    seq_multiplier #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Called at a falling edge; the following rising edge (E0) samples start.
    // Returns at the falling edge after E0.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // From the falling edge after E0, lat = n when done is seen after edge E0+n.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e);
        int lat;
        exp_q.push_back(e);
        issue(o, a, b);
        wait_done(lat);
        check({tag, "_lat"}, 32'(lat), 32'd33);
        check({tag, "_res"}, result, exp_q.pop_front());
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   lat;
        logic busy_ok;

        rst_n = 1'b1;
        start = 1'b0;
        op    = OP_MUL;
        rs1   = '0;
        rs2   = '0;

        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_done",   {31'b0, done}, 32'd0);
        check("rst_result", result,        32'd0);
        repeat (3) @(negedge clk);

        // Release and request on the very first rising edge afterwards.
        rst_n = 1'b1;
        run_op("mul_7x6", OP_MUL, 32'd7, 32'd6, 32'h0000_002A);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // Directed vectors.
        run_op("mulh_min",     OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_op("mulhu_max",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mul_max",      OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        run_op("mulhsu_m1",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulh_zero",    OP_MULH,   32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0000);
        run_op("mulh_neg",     OP_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
        run_op("mul_neg",      OP_MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1);
        run_op("mulhu_small",  OP_MULHU,  32'h8000_0000, 32'd2,         32'h0000_0001);
        run_op("mulhsu_min",   OP_MULHSU, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000);

        // start pulsed mid-operation with other operands must be ignored.
        exp_q.push_back(32'h0001_2340);
        issue(OP_MUL, 32'h0000_1234, 32'h0000_0010);
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (n == 5 || n == 20) begin
                start = 1'b1;
                op    = OP_MULHU;
                rs1   = 32'd9;
                rs2   = 32'd9;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("ign_lat",     32'(lat),         32'd33);
        check("ign_busy",    {31'b0, busy_ok}, 32'd1);
        check("ign_res",     result,           exp_q.pop_front());
        @(negedge clk);
        check("ign_pulse",   {31'b0, done},    32'd0);
        check("ign_hold",    result,           32'h0001_2340);
        repeat (3) @(negedge clk);
        check("ign_hold2",   result,           32'h0001_2340);

        // Reset in the middle of CALC (iteration 10).
        issue(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'b0, busy}, 32'd0);
        check("abort_done",   {31'b0, done}, 32'd0);
        check("abort_result", result,        32'd0);
        repeat (2) @(negedge clk);
        check("abort_hold_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        // A stray done from the aborted operation would shorten this latency.
        run_op("mul_3x3", OP_MUL, 32'd3, 32'd3, 32'h0000_0009);

        // Back-to-back: start held high during the DONE cycle.
        exp_q.push_back(32'h0000_0010);
        exp_q.push_back(32'h0000_000A);
        issue(OP_MUL, 32'd4, 32'd4);
        wait_done(lat);
        check("b2b_lat1", 32'(lat), 32'd33);
        check("b2b_res1", result,   exp_q.pop_front());
        issue(OP_MUL, 32'd2, 32'd5);
        check("b2b_busy", {31'b0, busy}, 32'd1);
        check("b2b_done_low", {31'b0, done}, 32'd0);
        wait_done(lat);
        check("b2b_lat2", 32'(lat), 32'd33);
        check("b2b_res2", result,   exp_q.pop_front());
        @(negedge clk);
        check("b2b_pulse", {31'b0, done}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only when not busy.
REQ-005 SHALL have port op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-006 SHALL have port rs1  input  XLEN  multiplicand, signed for MULH/MULHSU.
REQ-007 SHALL have port rs2  input  XLEN  multiplier, signed for MULH only.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking result valid.
REQ-010 SHALL have port result  output  XLEN  low word (MUL) or high word (others) of the 64-bit product.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-012 SHALL accept start only in IDLE or DONE, latching op, sign flag (XOR of operand signs per op) and the magnitudes of rs1 and rs2 at that edge; it SHALL then enter CALC.
REQ-013 SHALL ignore start in CALC or FIX, with no effect on the operation in progress.
REQ-014 SHALL load CALC with accumulator hi = 0, lo = |rs2| and iteration counter = 0.
REQ-015 SHALL, in each CALC cycle: if lo[0] = 1, form {cout, sum} = hi + |rs1|, otherwise {0, hi}; then shift {cout, sum, lo} right by one into {hi, lo}.
REQ-016 SHALL leave CALC after exactly 32 iterations (counter wraps 31 -> exit), then go to FIX.
REQ-017 SHALL, in FIX, two's-complement negate the 64-bit {hi, lo} when the sign flag is set, select the result word per op and register it into result.
REQ-018 SHALL go from FIX to DONE, assert done for exactly that one cycle, and then return to IDLE unless start is high.
REQ-019 SHALL have a fixed latency: with start sampled at edge E0, done is high from E0+33 to E0+34, and busy is high from E0+1 to E0+33.
REQ-020 SHALL hold result stable from done until the FIX of the next operation.
REQ-021 SHALL treat magnitude of -2^31 as unsigned 0x80000000, with no overflow.
REQ-022 SHALL produce 0 for any zero operand regardless of sign flag.

Reset
REQ-023 SHALL, while rst_n = 0 (at any time, including mid-CALC), force state IDLE, busy 0, done 0, result 0, counter 0, accumulator 0 immediately, without waiting for clk.
REQ-024 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-025 SHALL take the op encodings (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU) and FSM state encodings from a shared package, mul_pkg.
REQ-026 SHALL perform the CALC accumulate with one instance of the existing RippleCarryAdder, N = XLEN, cin = 0, with its cout feeding the shift.
REQ-027 SHALL contain no combinational multiply operator.

Verification
REQ-028 SHALL cover: MUL 7 x 6 -> result 0x0000002A; done exactly 33 cycles after the start edge; single-cycle pulse.
REQ-029 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-030 SHALL cover: MULHSU rs1 = 0xFFFFFFFF (-1), rs2 = 0xFFFFFFFF -> 0xFFFFFFFF; MULH 0xFFFFFFFB x 0 -> 0x00000000.
REQ-031 SHALL cover: start pulsed with new operands at cycles 5 and 20 after an accepted start -> ignored, first result unchanged, busy unbroken.
REQ-032 SHALL cover: rst_n low at CALC iteration 10 -> busy/done/result 0 asynchronously; done never asserts for the aborted operation; a new MUL 3 x 3 then gives 0x00000009.
REQ-033 SHALL cover: start high in the DONE cycle with MUL 2 x 5 -> accepted back-to-back; second done 33 cycles later with 0x0000000A.
